// File: rtl/register_bank_pkg.sv
// Shared constants for the Antares-R2 general-purpose register bank.
`ifndef REGISTER_BANK_PKG_SV
`define REGISTER_BANK_PKG_SV
package register_bank_pkg;

    // Default geometry: 32 registers of 32 bits
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Architectural register indices
    localparam logic [4:0] REG_ZERO = 5'd0;   // hardwired zero
    localparam logic [4:0] REG_RA   = 5'd31;  // link register, target of the jal path in the dest mux

    // Read-port lanes: A (rs) and B (rt)
    localparam int NUM_RD_PORTS = 2;
    localparam int RD_PORT_A    = 0;
    localparam int RD_PORT_B    = 1;

endpackage
`endif

// File: rtl/register_bank_if.sv
// Decode/write-back bus of the register bank: two read ports, one write port.
interface register_bank_if
    import register_bank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [ADDR_W-1:0] read_addr_a;
    logic [ADDR_W-1:0] read_addr_b;
    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data_a;
    logic [DATA_W-1:0] read_data_b;
    logic              write_ack;

    // Pipeline side: issues addresses and write-back data
    modport master (
        output read_addr_a, read_addr_b, write_en, write_addr, write_data,
        input  read_data_a, read_data_b, write_ack
    );

    // Register bank side
    modport slave (
        input  read_addr_a, read_addr_b, write_en, write_addr, write_data,
        output read_data_a, read_data_b, write_ack
    );
endinterface

// File: rtl/register_bank_bypass.sv
// Per-read-port select: zero register, then same-cycle write bypass, then storage.
module register_bank_bypass
    import register_bank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0]                      rd_addr,
    input  logic                                   byp_en,   // write_en qualified by reset deassertion
    input  logic [ADDR_W-1:0]                      wr_addr,
    input  logic [DATA_W-1:0]                      wr_data,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]     regs,
    output logic [DATA_W-1:0]                      rd_data
);

    // Priority read mux; r0 wins over any bypass so a write to r0 never leaks out
    always_comb begin
        rd_data = regs[rd_addr];
        if (rd_addr == ADDR_W'(REG_ZERO)) begin
            rd_data = '0;
        end else if (byp_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/register_bank.sv
// 32 x 32 register file: two combinational read ports with write bypass,
// one synchronous write port, registered write acknowledge.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic           clk,
    input  logic           reset,   // synchronous, active low
    register_bank_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0]        regs_q, regs_d;
    logic                                write_ack_q, write_ack_d;
    logic                                wr_commit;
    logic                                byp_en;
    logic [NUM_RD_PORTS-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD_PORTS-1:0][DATA_W-1:0] rd_data;

    // A write only lands (and is acknowledged) when it targets a non-zero register
    assign wr_commit = bus.write_en && (bus.write_addr != ADDR_W'(REG_ZERO));

    // Reset has priority over bypass so reads show the pre-edge contents during reset
    assign byp_en = bus.write_en && reset;

    // Next-state of storage and acknowledge; r0 is forced to zero every cycle
    always_comb begin
        regs_d      = regs_q;
        write_ack_d = 1'b0;
        if (wr_commit) begin
            regs_d[bus.write_addr] = bus.write_data;
            write_ack_d            = 1'b1;
        end
        regs_d[0] = '0;
    end

    // State update; reset clears the whole file in a single cycle and drops any write
    always_ff @(posedge clk) begin
        if (!reset) begin
            regs_q      <= '0;
            write_ack_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            write_ack_q <= write_ack_d;
        end
    end

    assign rd_addr[RD_PORT_A] = bus.read_addr_a;
    assign rd_addr[RD_PORT_B] = bus.read_addr_b;

    // One identical read-select lane per port
    for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_rd
        register_bank_bypass #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .rd_addr (rd_addr[g]),
            .byp_en  (byp_en),
            .wr_addr (bus.write_addr),
            .wr_data (bus.write_data),
            .regs    (regs_q),
            .rd_data (rd_data[g])
        );
    end

    assign bus.read_data_a = rd_data[RD_PORT_A];
    assign bus.read_data_b = rd_data[RD_PORT_B];
    assign bus.write_ack   = write_ack_q;

endmodule

// File: tb/tb_register_bank.sv
// Randomized self-checking bench for register_bank against an array reference model.
module tb_register_bank;
    import register_bank_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    register_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    register_bank #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: architectural register contents and expected ack
    logic [31:0] ref_regs [32];
    bit          ref_ack;
    bit          ref_known = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // What a read port should show this cycle, straight from the behavioural rules
    function automatic logic [31:0] ref_read(input logic [4:0] ra, input bit rst_n, input bit we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (ra == 5'd0) return 32'h0;
        if (rst_n && we && (wa == ra)) return wd;
        return ref_regs[ra];
    endfunction

    // One clock cycle: drive after negedge, check reads, take the edge, check ack
    task automatic step(input bit rst_n, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb, input string tag);
        reset           = rst_n;
        bus.write_en    = we;
        bus.write_addr  = wa;
        bus.write_data  = wd;
        bus.read_addr_a = ra;
        bus.read_addr_b = rb;
        #1;
        if (ref_known) begin
            check({tag, "/rda"}, bus.read_data_a, ref_read(ra, rst_n, we, wa, wd));
            check({tag, "/rdb"}, bus.read_data_b, ref_read(rb, rst_n, we, wa, wd));
        end
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
            ref_ack   = 1'b0;
            ref_known = 1'b1;
        end else begin
            ref_ack = we && (wa != 5'd0);
            if (ref_ack) ref_regs[wa] = wd;
        end
        #1;
        if (ref_known) check({tag, "/ack"}, {31'b0, bus.write_ack}, {31'b0, ref_ack});
        @(negedge clk);
    endtask

    initial begin
        bus.write_en    = 1'b0;
        bus.write_addr  = '0;
        bus.write_data  = '0;
        bus.read_addr_a = '0;
        bus.read_addr_b = '0;

        // Power-up reset, then reads must be zero
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "rst0");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, "rst1");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, "post_rst");

        // Reset clears a written register
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd1, "w5");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rst_clr");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "r5_zero");

        // Basic write: ack for exactly one cycle, readback on port B
        step(1'b1, 1'b1, 5'd7, 32'h12345678, 5'd1, 5'd2, "w7");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd7, "r7");

        // Writes to r0 are dropped and not acknowledged
        step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "w0");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "r0");

        // Same-cycle bypass on both ports, then persistence
        step(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, "byp9");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, "r9");

        // Reset vs write collision: no bypass, no write, no ack
        step(1'b1, 1'b1, 5'd3, 32'h00000077, 5'd1, 5'd2, "w3");
        step(1'b0, 1'b1, 5'd3, 32'h00000001, 5'd3, 5'd3, "coll");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, "r3");

        // Full sweep r1..r31, ack stays high throughout
        for (int i = 1; i < 32; i++)
            step(1'b1, 1'b1, 5'(i), i * 32'h01010101, 5'(i), 5'(32 - i), "sweep");
        for (int i = 0; i < 32; i++)
            step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "rdbk");

        // Random traffic with occasional reset and forced address collisions
        for (int n = 0; n < 400; n++) begin
            bit          rst_n;
            bit          we;
            logic [4:0]  wa, ra, rb;
            logic [31:0] wd;
            rst_n = ($urandom_range(0, 39) != 0);
            we    = ($urandom_range(0, 3) != 0);
            wa    = 5'($urandom_range(0, 31));
            wd    = $urandom;
            ra    = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb    = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            step(rst_n, we, wa, wd, ra, rb, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
